// File: rtl/ascii_pkg.sv
// Shared ASCII class ranges, conversion modes, flag layout and frame FSM states
// for the streaming character classifier.
package ascii_pkg;

   localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
   localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;
   localparam logic [7:0] NUM_LO         = 8'h30;
   localparam logic [7:0] NUM_HI         = 8'h39;
   localparam logic [7:0] CAP_LO         = 8'h41;
   localparam logic [7:0] CAP_HI         = 8'h5A;
   localparam logic [7:0] LC_LO          = 8'h61;
   localparam logic [7:0] LC_HI          = 8'h7A;
   localparam logic [7:0] CASE_OFFSET    = 8'h20;

   typedef enum logic [1:0] {
      CONV_PASS  = 2'd0,
      CONV_UPPER = 2'd1,
      CONV_LOWER = 2'd2,
      CONV_RSVD  = 2'd3
   } conv_mode_t;

   typedef struct packed {
      logic printable;
      logic num;
      logic lc;
      logic cap;
   } char_flags_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } frame_state_t;

   function automatic logic in_range(input logic [7:0] c,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/ascii_classify.sv
// Combinational classifier: class flags of the raw code plus the case-converted code.
module ascii_classify
   import ascii_pkg::*;
#(
   parameter int DATA_W = 7
) (
   input  logic [DATA_W-1:0] code_i,
   input  logic [1:0]        mode_i,
   output char_flags_t       flags_o,
   output logic [DATA_W-1:0] conv_code_o
);

   logic [7:0]  code8;
   char_flags_t flags;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      // Codes above 0x7F (8-bit mode) fall outside every range below.
      code8           = 8'(code_i);
      flags.printable = in_range(code8, ASCII_PRINT_LO, ASCII_PRINT_HI);
      flags.num       = in_range(code8, NUM_LO, NUM_HI);
      flags.lc        = in_range(code8, LC_LO, LC_HI);
      flags.cap       = in_range(code8, CAP_LO, CAP_HI);
      conv_code_o     = code_i;
      case (conv_mode_t'(mode_i))
         CONV_UPPER: if (flags.lc)  conv_code_o = DATA_W'(code8 - CASE_OFFSET);
         CONV_LOWER: if (flags.cap) conv_code_o = DATA_W'(code8 + CASE_OFFSET);
         default:    conv_code_o = code_i;
      endcase
      flags_o = flags;
   end

endmodule

// File: rtl/ascii_stream_classifier.sv
// Streaming ASCII classifier: one-deep registered pipeline with valid/ready,
// frame tracking on in_last and saturating per-frame class statistics.
module ascii_stream_classifier
   import ascii_pkg::*;
#(
   parameter int DATA_W = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_code,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_code,
   output logic [3:0]        out_flags,
   output logic              out_first,
   output logic              out_last,
   output logic              stat_valid,
   output logic [CNT_W-1:0]  stat_len,
   output logic [CNT_W-1:0]  stat_cap,
   output logic [CNT_W-1:0]  stat_lc,
   output logic [CNT_W-1:0]  stat_num,
   output logic [CNT_W-1:0]  stat_print,
   output logic              stat_sat
);

   // Returns {saturated, next_value}; saturated only when an increment was refused.
   function automatic logic [CNT_W:0] inc_sat(input logic [CNT_W-1:0] c,
                                             input logic             en);
      logic full;
      full = &c;
      if (en && !full) return {1'b0, c + CNT_W'(1)};
      return {en && full, c};
   endfunction

   char_flags_t       cls_flags;
   logic [DATA_W-1:0] cls_code;

   ascii_classify #(.DATA_W(DATA_W)) u_classify (
      .code_i      (in_code),
      .mode_i      (mode),
      .flags_o     (cls_flags),
      .conv_code_o (cls_code)
   );

   frame_state_t      state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_code_q;
   char_flags_t       out_flags_q;
   logic              out_first_q, out_last_q;

   logic [CNT_W-1:0]  len_q, cap_q, lc_q, num_q, print_q;
   logic [CNT_W-1:0]  len_d, cap_d, lc_d, num_d, print_d;
   logic              len_s, cap_s, lc_s, num_s, print_s;
   logic              frame_sat_q, sat_now;

   logic              stat_valid_q;
   logic [CNT_W-1:0]  stat_len_q, stat_cap_q, stat_lc_q, stat_num_q, stat_print_q;
   logic              stat_sat_q;

   logic              accept;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         state_d     = in_last ? IDLE : FRAME;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      {len_s,   len_d}   = inc_sat(len_q,   1'b1);
      {cap_s,   cap_d}   = inc_sat(cap_q,   cls_flags.cap);
      {lc_s,    lc_d}    = inc_sat(lc_q,    cls_flags.lc);
      {num_s,   num_d}   = inc_sat(num_q,   cls_flags.num);
      {print_s, print_d} = inc_sat(print_q, cls_flags.printable);
      sat_now = len_s | cap_s | lc_s | num_s | print_s;
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         out_valid_q  <= 1'b0;
         out_code_q   <= '0;
         out_flags_q  <= '0;
         out_first_q  <= 1'b0;
         out_last_q   <= 1'b0;
         len_q        <= '0;
         cap_q        <= '0;
         lc_q         <= '0;
         num_q        <= '0;
         print_q      <= '0;
         frame_sat_q  <= 1'b0;
         stat_valid_q <= 1'b0;
         stat_len_q   <= '0;
         stat_cap_q   <= '0;
         stat_lc_q    <= '0;
         stat_num_q   <= '0;
         stat_print_q <= '0;
         stat_sat_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         stat_valid_q <= accept && in_last;
         if (accept) begin
            out_code_q  <= cls_code;
            out_flags_q <= cls_flags;
            out_first_q <= (state_q == IDLE);
            out_last_q  <= in_last;
            if (in_last) begin
               // Snapshot includes the closing character; counters restart together.
               stat_len_q   <= len_d;
               stat_cap_q   <= cap_d;
               stat_lc_q    <= lc_d;
               stat_num_q   <= num_d;
               stat_print_q <= print_d;
               stat_sat_q   <= frame_sat_q | sat_now;
               len_q        <= '0;
               cap_q        <= '0;
               lc_q         <= '0;
               num_q        <= '0;
               print_q      <= '0;
               frame_sat_q  <= 1'b0;
            end else begin
               len_q        <= len_d;
               cap_q        <= cap_d;
               lc_q         <= lc_d;
               num_q        <= num_d;
               print_q      <= print_d;
               frame_sat_q  <= frame_sat_q | sat_now;
            end
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_code   = out_code_q;
   assign out_flags  = out_flags_q;
   assign out_first  = out_first_q;
   assign out_last   = out_last_q;
   assign stat_valid = stat_valid_q;
   assign stat_len   = stat_len_q;
   assign stat_cap   = stat_cap_q;
   assign stat_lc    = stat_lc_q;
   assign stat_num   = stat_num_q;
   assign stat_print = stat_print_q;
   assign stat_sat   = stat_sat_q;

endmodule

// File: tb/tb_ascii_stream_classifier.sv
// Directed bench: a 7-bit/16-bit instance and an 8-bit/4-bit instance share one
// input stream; each scenario task checks its own expected values.
module tb_ascii_stream_classifier;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       in_valid, in_last, out_ready;
   logic [7:0] in_code;

   logic        in_ready0, out_valid0, out_first0, out_last0, stat_valid0, stat_sat0;
   logic [6:0]  out_code0;
   logic [3:0]  out_flags0;
   logic [15:0] stat_len0, stat_cap0, stat_lc0, stat_num0, stat_print0;

   logic        in_ready1, out_valid1, out_first1, out_last1, stat_valid1, stat_sat1;
   logic [7:0]  out_code1;
   logic [3:0]  out_flags1;
   logic [3:0]  stat_len1, stat_cap1, stat_lc1, stat_num1, stat_print1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ascii_stream_classifier #(.DATA_W(7), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready0),
      .in_code(in_code[6:0]), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
      .out_code(out_code0), .out_flags(out_flags0), .out_first(out_first0), .out_last(out_last0),
      .stat_valid(stat_valid0), .stat_len(stat_len0), .stat_cap(stat_cap0), .stat_lc(stat_lc0),
      .stat_num(stat_num0), .stat_print(stat_print0), .stat_sat(stat_sat0)
   );

   ascii_stream_classifier #(.DATA_W(8), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready1),
      .in_code(in_code), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
      .out_code(out_code1), .out_flags(out_flags1), .out_first(out_first1), .out_last(out_last1),
      .stat_valid(stat_valid1), .stat_len(stat_len1), .stat_cap(stat_cap1), .stat_lc(stat_lc1),
      .stat_num(stat_num1), .stat_print(stat_print1), .stat_sat(stat_sat1)
   );

   // Presents one character for one edge; callers keep out_ready high so it is accepted.
   task automatic xfer(input logic [7:0] c, input logic l, input logic [1:0] m);
      in_valid = 1'b1;
      in_code  = c;
      in_last  = l;
      mode     = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_code = 8'h00;
      mode = 2'd0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({out_valid0, out_code0, out_flags0, out_first0, out_last0, stat_valid0} !== '0)
         $display("FAIL reset_out: got %h want 0",
                  {out_valid0, out_code0, out_flags0, out_first0, out_last0, stat_valid0});
      total++;
      if ({stat_len0, stat_cap0, stat_lc0, stat_num0, stat_print0, stat_sat0} !== '0)
         $display("FAIL reset_stat: got %h want 0",
                  {stat_len0, stat_cap0, stat_lc0, stat_num0, stat_print0, stat_sat0});
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({in_ready0, out_valid0} !== 2'b10) begin
         bad++;
         $display("FAIL reset_ready: got %b want 10", {in_ready0, out_valid0});
      end
   endtask

   task automatic test_hi_frame();
      logic [7:0] s [6] = '{8'h48, 8'h69, 8'h20, 8'h34, 8'h32, 8'h21};
      logic [3:0] f [6] = '{4'b1001, 4'b1010, 4'b1000, 4'b1100, 4'b1100, 4'b1000};
      total++;
      if (out_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL hi_pre_valid: got %b want 0", out_valid0);
      end
      for (int i = 0; i < 6; i++) begin
         xfer(s[i], i == 5, 2'd0);
         total++;
         if ({out_valid0, out_code0} !== {1'b1, s[i][6:0]}) begin
            bad++;
            $display("FAIL hi_code[%0d]: got %h want %h", i, {out_valid0, out_code0}, {1'b1, s[i][6:0]});
         end
         total++;
         if (out_flags0 !== f[i]) begin
            bad++;
            $display("FAIL hi_flags[%0d]: got %b want %b", i, out_flags0, f[i]);
         end
         total++;
         if ({out_first0, out_last0, stat_valid0} !== {i == 0, i == 5, i == 5}) begin
            bad++;
            $display("FAIL hi_marks[%0d]: got %b want %b", i,
                     {out_first0, out_last0, stat_valid0}, {i == 0, i == 5, i == 5});
         end
      end
      total++;
      if ({stat_len0, stat_cap0, stat_lc0, stat_num0, stat_print0, stat_sat0} !==
          {16'd6, 16'd1, 16'd1, 16'd2, 16'd6, 1'b0}) begin
         bad++;
         $display("FAIL hi_stats: got %h want %h",
                  {stat_len0, stat_cap0, stat_lc0, stat_num0, stat_print0, stat_sat0},
                  {16'd6, 16'd1, 16'd1, 16'd2, 16'd6, 1'b0});
      end
      @(posedge clk);
      #1;
      total++;
      if ({stat_valid0, out_valid0, stat_len0} !== {1'b0, 1'b0, 16'd6}) begin
         bad++;
         $display("FAIL hi_after: got %h want %h", {stat_valid0, out_valid0, stat_len0},
                  {1'b0, 1'b0, 16'd6});
      end
   endtask

   task automatic test_conversion();
      logic [7:0] s [6] = '{8'h61, 8'h5A, 8'h7B, 8'h61, 8'h5A, 8'h40};
      logic [7:0] e [6] = '{8'h41, 8'h5A, 8'h7B, 8'h61, 8'h7A, 8'h40};
      logic [3:0] f [6] = '{4'b1010, 4'b1001, 4'b1000, 4'b1010, 4'b1001, 4'b1000};
      for (int i = 0; i < 6; i++) begin
         xfer(s[i], (i % 3) == 2, (i < 3) ? 2'd1 : 2'd2);
         total++;
         if ({1'b0, out_code0} !== e[i]) begin
            bad++;
            $display("FAIL conv_code[%0d]: got %h want %h", i, out_code0, e[i]);
         end
         total++;
         if (out_flags0 !== f[i]) begin
            bad++;
            $display("FAIL conv_flags[%0d]: got %b want %b", i, out_flags0, f[i]);
         end
      end
   endtask

   task automatic test_back_pressure();
      xfer(8'h61, 1'b0, 2'd0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 8'h62;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         total++;
         if ({in_ready0, out_valid0, out_code0} !== {1'b0, 1'b1, 7'h61}) begin
            bad++;
            $display("FAIL stall[%0d]: got %h want %h", k, {in_ready0, out_valid0, out_code0},
                     {1'b0, 1'b1, 7'h61});
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({out_valid0, out_code0, out_first0} !== {1'b1, 7'h62, 1'b0}) begin
         bad++;
         $display("FAIL stall_release: got %h want %h", {out_valid0, out_code0, out_first0},
                  {1'b1, 7'h62, 1'b0});
      end
      xfer(8'h63, 1'b0, 2'd0);
      xfer(8'h64, 1'b1, 2'd0);
      total++;
      if ({out_code0, stat_valid0, stat_len0, stat_lc0} !== {7'h64, 1'b1, 16'd4, 16'd4}) begin
         bad++;
         $display("FAIL stall_stats: got %h want %h", {out_code0, stat_valid0, stat_len0, stat_lc0},
                  {7'h64, 1'b1, 16'd4, 16'd4});
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] c [18] = '{8'h1F, 8'h20, 8'h2F, 8'h30, 8'h39, 8'h3A, 8'h40, 8'h41, 8'h5A,
                             8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'h7E, 8'h7F, 8'h80, 8'hFF};
      logic [3:0] f [18] = '{4'b0000, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1000, 4'b1000,
                             4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1010, 4'b1010, 4'b1000,
                             4'b1000, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 18; i++) begin
         xfer(c[i], 1'b1, 2'd0);
         total++;
         if ({out_flags1, out_code1, out_first1} !== {f[i], c[i], 1'b1}) begin
            bad++;
            $display("FAIL bound8[%h]: got %h want %h", c[i], {out_flags1, out_code1, out_first1},
                     {f[i], c[i], 1'b1});
         end
         if (i < 16) begin
            total++;
            if (out_flags0 !== f[i]) begin
               bad++;
               $display("FAIL bound7[%h]: got %b want %b", c[i], out_flags0, f[i]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) xfer(8'h37, i == 19, 2'd0);
      total++;
      if ({stat_valid1, stat_len1, stat_cap1, stat_lc1, stat_num1, stat_print1, stat_sat1} !==
          {1'b1, 4'd15, 4'd0, 4'd0, 4'd15, 4'd15, 1'b1}) begin
         bad++;
         $display("FAIL sat_stats: got %h want %h",
                  {stat_valid1, stat_len1, stat_cap1, stat_lc1, stat_num1, stat_print1, stat_sat1},
                  {1'b1, 4'd15, 4'd0, 4'd0, 4'd15, 4'd15, 1'b1});
      end
      total++;
      if ({stat_len0, stat_num0, stat_sat0} !== {16'd20, 16'd20, 1'b0}) begin
         bad++;
         $display("FAIL wide_stats: got %h want %h", {stat_len0, stat_num0, stat_sat0},
                  {16'd20, 16'd20, 1'b0});
      end
      xfer(8'h41, 1'b0, 2'd0);
      xfer(8'h42, 1'b1, 2'd0);
      total++;
      if ({stat_valid1, stat_len1, stat_cap1, stat_num1, stat_sat1} !==
          {1'b1, 4'd2, 4'd2, 4'd0, 1'b0}) begin
         bad++;
         $display("FAIL sat_next: got %h want %h",
                  {stat_valid1, stat_len1, stat_cap1, stat_num1, stat_sat1},
                  {1'b1, 4'd2, 4'd2, 4'd0, 1'b0});
      end
   endtask

   task automatic test_mid_frame_reset();
      xfer(8'h78, 1'b0, 2'd0);
      xfer(8'h79, 1'b0, 2'd0);
      xfer(8'h7A, 1'b0, 2'd0);
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid0, out_code0, out_flags0, stat_valid0, stat_len0} !== '0) begin
         bad++;
         $display("FAIL midrst_out: got %h want 0",
                  {out_valid0, out_code0, out_flags0, stat_valid0, stat_len0});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({stat_valid0, stat_valid1, out_valid0} !== 3'b000) begin
         bad++;
         $display("FAIL midrst_quiet: got %b want 000", {stat_valid0, stat_valid1, out_valid0});
      end
      xfer(8'h41, 1'b1, 2'd0);
      total++;
      if ({out_first0, stat_valid0, stat_len0, stat_cap0} !== {1'b1, 1'b1, 16'd1, 16'd1}) begin
         bad++;
         $display("FAIL midrst_next: got %h want %h", {out_first0, stat_valid0, stat_len0, stat_cap0},
                  {1'b1, 1'b1, 16'd1, 16'd1});
      end
   endtask

   initial begin
      test_reset();
      test_hi_frame();
      test_conversion();
      test_back_pressure();
      test_boundaries();
      test_saturation();
      test_mid_frame_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of run want finish");
      $fatal(1);
   end

endmodule

// File: doc/ascii_stream_classifier.md
Name: ascii_stream_classifier

Overview:
Streaming successor to the combinational ASCII character classifier. Accepts one character per cycle over a valid/ready handshake and emits it one cycle later, registered, with class flags and optional case conversion. Accumulates per-frame class statistics, delimited by in_last, and presents them as a one-cycle snapshot when a frame closes. Sits between a UART/byte-stream receiver and downstream text-parsing logic.

Parameters:
DATA_W, 7, character width; legal values 7 or 8. When 8, codes 0x80-0xFF are non-printable and belong to no class.
CNT_W, 16, width of every frame statistic counter; minimum 4.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  2  case conversion, sampled on accept: 0 pass, 1 to-upper, 2 to-lower, 3 pass
in_valid  input  1  input character valid
in_ready  output  1  block can accept a character
in_code  input  DATA_W  input character
in_last  input  1  last character of the frame
out_valid  output  1  output character valid
out_ready  input  1  downstream accepts
out_code  output  DATA_W  converted character
out_flags  output  4  {is_printable, is_num, is_lc, is_cap}, classified on the unconverted code
out_first  output  1  first character of the frame
out_last  output  1  copy of in_last
stat_valid  output  1  one-cycle pulse, frame statistics valid
stat_len  output  CNT_W  characters in the frame
stat_cap, stat_lc, stat_num, stat_print  output  CNT_W  class counts for the frame
stat_sat  output  1  some counter saturated during the frame

Behaviour:
- Reset (async assert, sync deassert externally): out_valid=0, all out_* fields=0, stat_*=0, stat_valid=0, frame counters=0, FSM=IDLE. in_ready=1 once reset is released.
- Classes: printable 0x20-0x7E; num 0x30-0x39; cap 0x41-0x5A; lc 0x61-0x7A. Classes are mutually exclusive except printable. 0x7F and controls are no class.
- Conversion: mode 1 subtracts 0x20 from lc codes only. Mode 2 adds 0x20 to cap codes only. All other codes pass unchanged.
- Handshake: accept = in_valid && in_ready. in_ready = !out_valid || out_ready. The pipeline stage is a single register, giving full throughput with back-to-back accepts. Latency is 1 cycle from accept to out_valid. Output fields hold stable while out_valid && !out_ready. in_valid without in_ready is ignored.
- FSM with states IDLE and FRAME:
  - IDLE, accept, !in_last -> FRAME.
  - IDLE, accept, in_last -> IDLE (one-character frame).
  - FRAME, accept, in_last -> IDLE.
  - out_first is registered as 1 for any character accepted in IDLE.
- Counters: on each accept, len and the matching class counters increment, saturating at 2^CNT_W-1. A saturating increment latches a sticky frame_sat flag.
- Frame close: on an accept with in_last, the stat_* registers load the counters including the current character. stat_sat loads frame_sat OR a saturation on this character. stat_valid pulses the next cycle, aligned with that character's out_valid first asserting. Counters and frame_sat clear in the same edge. stat_* values hold until the next frame close.
- stat_valid is not back-pressured: it pulses once even if out_ready is low.
- Mid-frame reset discards the partial frame and produces no stat_valid.

Decomposition:
- Package ascii_pkg holds:
  - range constants (ASCII_PRINT_LO/HI, NUM_LO/HI, CAP_LO/HI, LC_LO/HI, CASE_OFFSET=0x20);
  - typedef enum conv_mode_t {CONV_PASS, CONV_UPPER, CONV_LOWER, CONV_RSVD};
  - typedef struct packed char_flags_t {printable, num, lc, cap};
  - typedef enum frame_state_t {IDLE, FRAME}.
- Sub-module ascii_classify (combinational, parameter DATA_W) takes code and mode and returns char_flags_t plus the converted code. The top level holds the handshake register, FSM and counters.

Test Plan:
- mode=0, frame "Hi 42!" (0x48,0x69,0x20,0x34,0x32,0x21), last on 0x21, out_ready=1 -> output codes unchanged, 1-cycle latency, out_first on 0x48. Stats: len=6, cap=1, lc=1, num=2, print=6, stat_sat=0, single stat_valid pulse.
- mode=1 on "aZ{" then mode=2 on "aZ@" -> outputs 0x41,0x5A,0x7B then 0x61,0x7A,0x40. Flags follow the input: 'a' is lc, 'Z' is cap.
- out_ready held low 3 cycles mid-stream with in_valid=1 -> in_ready=0 while stalled, out_code stable, no character lost or duplicated, final stat_len correct.
- CNT_W=4, 20-character frame of '7' -> stat_len=15, stat_num=15, stat_print=15, stat_sat=1. The next 2-character frame gives stat_len=2, stat_sat=0.
- Control/boundary codes 0x1F,0x20,0x2F,0x30,0x39,0x3A,0x40,0x41,0x5A,0x5B,0x60,0x61,0x7A,0x7B,0x7E,0x7F (DATA_W=8 adds 0x80,0xFF) -> flags exactly match the class ranges.
- Assert rst_n low after 3 characters of an open frame -> outputs zero immediately with no stat_valid. The next frame "A" with last gives out_first=1 and stat_len=1, stat_cap=1.
